io_spi_rx_peripheral: RTL and testbench
=======================================

// Module: io_spi_rx_peripheral
// PURPOSE
//  SPI peripheral (slave) end of the IO SPI link: mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames.
//  Oversamples external SCLK/CS_N/MOSI in the clk_in domain; shifts MOSI into rx_buffer and drives
//  MISO from a one-deep transmit holding register. Multiple back-to-back bytes per CS_N assertion.
//  Sits at the IO board pins, opposite the controller-side SPI TX interface.
// PARAMETERS
//  SYNC_STAGES  2      flip-flop synchroniser depth on spi_sclk, spi_cs_n and spi_mosi (min 2)
//  IDLE_BYTE    8'hFF  byte shifted out on MISO when the holding register is empty at byte start
// PORTS
//  clk_in       in   1  system clock; SCLK period must be >= 8 clk_in periods
//  reset        in   1  asynchronous, active-high reset
//  spi_sclk     in   1  SPI clock from the controller (asynchronous to clk_in)
//  spi_cs_n     in   1  chip select, active low (asynchronous)
//  spi_mosi     in   1  controller-out data (asynchronous)
//  spi_miso     out  1  peripheral-out data
//  spi_miso_oe  out  1  MISO output enable (1 while selected); top level builds the tristate
//  tx_data      in   8  byte to send on the next frame
//  tx_load      in   1  capture tx_data into the holding register (honoured only when tx_ready=1)
//  tx_ready     out  1  holding register empty
//  tx_underrun  out  1  1-cycle pulse: a byte started with the holding register empty
//  rx_buffer    out  8  last complete received byte; held until the next byte completes
//  rx_valid     out  1  1-cycle pulse: rx_buffer updated
//  busy         out  1  synchronised CS_N is asserted
// BEHAVIOUR
//  Reset: spi_miso=0, spi_miso_oe=0, rx_buffer=0, rx_valid=0, tx_ready=1, tx_underrun=0, busy=0,
//   bit counter=0, state=IDLE, holding register empty.
//  Sync: each async input passes through SYNC_STAGES flops. Edges are detected on the last stage
//   against a registered copy. Pin-to-detect latency is SYNC_STAGES+1 clk_in cycles.
//  FSM IDLE -> ACTIVE on the CS_N falling edge:
//   - load the TX shift register from holding, or IDLE_BYTE plus a tx_underrun pulse if holding is empty;
//   - spi_miso=bit7 and spi_miso_oe=1 in the same cycle; bit_cnt=0; busy=1.
//  ACTIVE, SCLK rising edge: rx_shift={rx_shift[6:0],mosi_sync}; bit_cnt+1.
//   When bit_cnt goes 7->8: rx_buffer<=new byte, rx_valid=1 for one cycle, bit_cnt wraps to 0.
//  ACTIVE, SCLK falling edge:
//   - bit_cnt!=0: shift TX left, spi_miso=next bit;
//   - bit_cnt==0 (byte boundary): reload from holding/IDLE_BYTE as on CS_N fall, spi_miso=bit7.
//  ACTIVE -> IDLE on the CS_N rising edge:
//   - spi_miso_oe=0, spi_miso=0, busy=0;
//   - a partial byte (bit_cnt 1..7) is discarded: no rx_valid, rx_buffer unchanged, bit_cnt=0;
//   - the holding register is not touched.
//  SCLK edges while IDLE are ignored.
//  Holding register:
//   - tx_load with tx_ready=1 -> capture tx_data, tx_ready=0 next cycle;
//   - tx_load with tx_ready=0 is ignored (data dropped, no flag);
//   - consumption at byte start -> tx_ready=1 next cycle.
//  Simultaneous events:
//   - CS_N rise and SCLK edge detected in the same cycle: CS_N wins (abort), the SCLK edge is dropped;
//   - tx_load and byte-start reload in the same cycle with holding empty: the reload sends IDLE_BYTE
//     (underrun) and the new data is captured for the next byte;
//   - tx_load with holding full and a reload in the same cycle: the old byte is consumed and tx_load is
//     ignored (tx_ready was 0).
//  Reset asserted mid-frame: immediate return to the reset values. The frame is not resumed until the
//   next CS_N falling edge.
// STRUCTURE
//  Shared package io_spi_pkg: SPI_FRAME_BITS=8, IDLE_BYTE default, FSM state encoding
//   (ST_IDLE, ST_ACTIVE), bit counter width localparam.
//  One sub-module, io_spi_sync_edge: N-stage synchroniser plus rise/fall pulse outputs.
//   Instantiated three times here: sclk and cs_n use the edge outputs; mosi uses the level only.
//  Top holds the FSM, bit counter, TX/RX shift registers and the holding register.
// TESTING (bench controller model, SCLK = 16 clk_in cycles)
//  1 Preload tx_data=8'hA5; CS_N low; send 8'h3C; CS_N high
//    -> MISO bits 1,0,1,0,0,1,0,1; rx_buffer=8'h3C; exactly one rx_valid; tx_ready=1.
//  2 No tx_load; one frame sending 8'h00 -> MISO=8'hFF; tx_underrun exactly once; rx_buffer=8'h00.
//  3 Three bytes under one CS_N, sending 8'h11,8'h22,8'h33; reload tx_data=8'h01,8'h02,8'h03 on each
//    tx_ready -> three rx_valid pulses with matching rx_buffer; MISO=01,02,03.
//  4 CS_N high after 5 SCLK rises -> no rx_valid, rx_buffer keeps its prior value, spi_miso_oe=0;
//    next full frame of 8'h5A is received correctly.
//  5 tx_load 8'h77 then 8'h88 before any frame -> frame returns 8'h77; 8'h88 was dropped.
//  6 reset pulsed after bit 4 of a frame -> all outputs at reset values; SCLK ignored until a new
//    CS_N fall; following frame of 8'hC3 is received correctly.

Source files
------------

// File: rtl/io_spi_pkg.sv
// -----------------------------------------------------------------------------
// io_spi_pkg
// Shared definitions for the IO SPI link: frame size, default idle byte,
// bit counter width and the peripheral FSM state encoding.
// -----------------------------------------------------------------------------
package io_spi_pkg;

  localparam int SPI_FRAME_BITS = 8;
  localparam int BIT_CNT_W      = $clog2(SPI_FRAME_BITS);

  localparam logic [SPI_FRAME_BITS-1:0] IDLE_BYTE_DEFAULT = 8'hFF;

  // Counter value while the last bit of a frame is being received.
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(SPI_FRAME_BITS - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/io_spi_rx_peripheral_if.sv
// -----------------------------------------------------------------------------
// io_spi_rx_peripheral_if
// Bundles the SPI pins and the local byte handshake of the SPI peripheral.
//   slave  : the peripheral (receives SCLK/CS_N/MOSI, tx_data/tx_load;
//            drives MISO, MISO enable, tx_ready, tx_underrun, rx_*, busy)
//   master : the SPI controller plus the local host feeding tx_data
// -----------------------------------------------------------------------------
interface io_spi_rx_peripheral_if;
  import io_spi_pkg::*;

  logic                      spi_sclk;
  logic                      spi_cs_n;
  logic                      spi_mosi;
  logic                      spi_miso;
  logic                      spi_miso_oe;
  logic [SPI_FRAME_BITS-1:0] tx_data;
  logic                      tx_load;
  logic                      tx_ready;
  logic                      tx_underrun;
  logic [SPI_FRAME_BITS-1:0] rx_buffer;
  logic                      rx_valid;
  logic                      busy;

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, tx_data, tx_load,
    output spi_miso, spi_miso_oe, tx_ready, tx_underrun, rx_buffer, rx_valid, busy
  );

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, tx_data, tx_load,
    input  spi_miso, spi_miso_oe, tx_ready, tx_underrun, rx_buffer, rx_valid, busy
  );

endinterface

// File: rtl/io_spi_sync_edge.sv
// -----------------------------------------------------------------------------
// io_spi_sync_edge
// STAGES-deep flip-flop synchroniser for one asynchronous input, followed by
// a registered copy of the last stage used for edge detection.
//   clk, rst  : clock, asynchronous active-high reset
//   async_in  : asynchronous input pin
//   level     : synchronised level (last synchroniser stage)
//   rise/fall : one-cycle pulses on a synchronised 0->1 / 1->0 transition
// Every stage resets to 0. For CS_N this means a select held low across reset
// produces no falling edge, so a frame only starts on a genuine CS_N fall.
// -----------------------------------------------------------------------------
module io_spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  if (STAGES < 2) begin : g_bad_stages
    $error("io_spi_sync_edge: STAGES must be at least 2");
  end

  logic [STAGES-1:0] sync_q, sync_d;
  logic              last_q, last_d;

  // NOTE: every signal assigned here gets its default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_in};
    last_d = sync_q[STAGES-1];
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the values from before the clock edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  =  level & ~last_q;
  assign fall  = ~level &  last_q;

endmodule

// File: rtl/io_spi_rx_peripheral.sv
// -----------------------------------------------------------------------------
// io_spi_rx_peripheral
// SPI mode-0 peripheral, MSB first, 8-bit frames, several bytes per CS_N.
// SCLK, CS_N and MOSI are oversampled in the clk_in domain.
//   clk_in : system clock (SCLK period must be >= 8 clk_in periods)
//   reset  : asynchronous, active-high reset
//   bus    : SPI pins (sclk, cs_n, mosi, miso, miso_oe) plus the local side:
//            tx_data/tx_load/tx_ready/tx_underrun for the one-deep transmit
//            holding register, rx_buffer/rx_valid for received bytes, busy.
// -----------------------------------------------------------------------------
module io_spi_rx_peripheral
  import io_spi_pkg::*;
#(
  parameter int                        SYNC_STAGES = 2,
  parameter logic [SPI_FRAME_BITS-1:0] IDLE_BYTE   = IDLE_BYTE_DEFAULT
) (
  input  logic                   clk_in,
  input  logic                   reset,
  io_spi_rx_peripheral_if.slave  bus
);

  // ---------------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------------
  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic cs_rise, cs_fall, cs_level_unused;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  io_spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk_in), .rst(reset), .async_in(bus.spi_sclk),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  io_spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs_n (
    .clk(clk_in), .rst(reset), .async_in(bus.spi_cs_n),
    .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
  );

  io_spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk_in), .rst(reset), .async_in(bus.spi_mosi),
    .level(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  spi_state_e                state_q, state_d;
  logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [SPI_FRAME_BITS-2:0] rx_shift_q, rx_shift_d;   // bits received so far
  logic [SPI_FRAME_BITS-1:0] tx_shift_q, tx_shift_d;   // MISO is always bit 7
  logic [SPI_FRAME_BITS-1:0] rx_buffer_q, rx_buffer_d;
  logic                      rx_valid_q, rx_valid_d;
  logic                      underrun_q, underrun_d;
  logic [SPI_FRAME_BITS-1:0] hold_q, hold_d;
  logic                      hold_full_q, hold_full_d;

  logic                      start_byte;
  logic [SPI_FRAME_BITS-1:0] rx_byte;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_buffer_d = rx_buffer_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    start_byte  = 1'b0;
    rx_byte     = {rx_shift_q, mosi_sync};

    case (state_q)
      ST_IDLE: begin
        // SCLK edges are ignored until the controller selects us.
        if (cs_fall) begin
          state_d    = ST_ACTIVE;
          bit_cnt_d  = '0;
          start_byte = 1'b1;
        end
      end

      ST_ACTIVE: begin
        // Deselect takes priority over an SCLK edge seen in the same cycle;
        // any partial byte is dropped and the holding register is left alone.
        if (cs_rise) begin
          state_d    = ST_IDLE;
          bit_cnt_d  = '0;
          tx_shift_d = '0;
        end else if (sclk_rise) begin
          rx_shift_d = rx_byte[SPI_FRAME_BITS-2:0];
          bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);   // wraps to 0 after bit 7
          if (bit_cnt_q == LAST_BIT) begin
            rx_buffer_d = rx_byte;
            rx_valid_d  = 1'b1;
          end
        end else if (sclk_fall) begin
          // A falling edge with the counter at 0 follows a completed byte,
          // so it starts the next one instead of shifting.
          if (bit_cnt_q != '0) begin
            tx_shift_d = {tx_shift_q[SPI_FRAME_BITS-2:0], 1'b0};
          end else begin
            start_byte = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (start_byte) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d = IDLE_BYTE;
        underrun_d = 1'b1;
      end
    end

    // Acceptance is judged on the flag before this cycle's reload: a load
    // racing a reload of an empty register lands for the following byte,
    // while a load racing the consumption of a full register is dropped.
    if (bus.tx_load && !hold_full_q) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_buffer_q <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_buffer_q <= rx_buffer_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.spi_miso    = tx_shift_q[SPI_FRAME_BITS-1];
  assign bus.spi_miso_oe = (state_q == ST_ACTIVE);
  assign bus.busy        = (state_q == ST_ACTIVE);
  assign bus.tx_ready    = ~hold_full_q;
  assign bus.tx_underrun = underrun_q;
  assign bus.rx_buffer   = rx_buffer_q;
  assign bus.rx_valid    = rx_valid_q;

endmodule

// File: tb/tb_io_spi_rx_peripheral.sv
// -----------------------------------------------------------------------------
// tb_io_spi_rx_peripheral
// Controller-side model of an SPI mode-0 master (SCLK = 16 clk_in cycles)
// plus a byte-level model of the peripheral's holding register. Expected
// received bytes and expected MISO bytes are queued by the stimulus; a monitor
// pops and compares them as the DUT produces rx_valid pulses and as the
// controller finishes sampling each MISO byte.
// -----------------------------------------------------------------------------
module tb_io_spi_rx_peripheral;

  localparam int HALF = 8;   // clk_in cycles per SCLK half period
  localparam int SYNC = 2;

  logic clk_in = 1'b0;
  logic reset;
  always #5 clk_in = ~clk_in;

  io_spi_rx_peripheral_if bus ();

  io_spi_rx_peripheral #(.SYNC_STAGES(SYNC), .IDLE_BYTE(8'hFF)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Scoreboard queues
  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_miso_q[$];
  logic [7:0] obs_miso_q[$];

  // Byte-level model of the peripheral
  logic       m_full = 1'b0;
  logic [7:0] m_hold = 8'h00;
  logic [7:0] m_rx   = 8'h00;
  logic [7:0] cur_exp_miso = 8'h00;
  int         exp_underruns = 0, exp_rx_valids = 0;
  int         act_underruns = 0, act_rx_valids = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // A byte starts: it carries the held byte if there is one, else the idle byte.
  task automatic model_byte_start();
    if (m_full) begin
      cur_exp_miso = m_hold;
      m_full = 1'b0;
    end else begin
      cur_exp_miso = 8'hFF;
      exp_underruns++;
    end
  endtask

  task automatic load(input logic [7:0] d);
    bus.tx_data = d;
    bus.tx_load = 1'b1;
    if (!m_full) begin
      m_hold = d;
      m_full = 1'b1;
    end
    tick(1);
    bus.tx_load = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.tx_ready !== 1'b1 && n < 32) begin
      tick(1);
      n++;
    end
    if (n >= 32) check("tx_ready_timeout", 32'(bus.tx_ready), 32'd1);
  endtask

  task automatic cs_fall();
    bus.spi_cs_n = 1'b0;
    model_byte_start();
  endtask

  // One byte on the wire. nrises<8 aborts after that many rising edges, either
  // by deselecting together with the next SCLK fall or (abort_by_reset) by
  // returning with SCLK high for the caller to reset. refill_mode: 0 none,
  // 1 wait for tx_ready then load, 2 load blindly; done mid-byte. bload_en
  // issues a load in the very cycle the DUT reacts to the byte-boundary fall.
  task automatic send_byte(input logic [7:0] d, input bit last, input int nrises,
                           input bit abort_by_reset, input int refill_mode,
                           input logic [7:0] refill_data, input bit bload_en,
                           input logic [7:0] bload_data);
    logic [7:0] obs;
    bit         fb;
    obs = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bus.spi_mosi = d[7-i];
      if (i == 3 && refill_mode == 1) begin
        wait_ready();
        load(refill_data);
      end else if (i == 3 && refill_mode == 2) begin
        load(refill_data);
      end
      tick(HALF);
      bus.spi_sclk = 1'b1;
      obs[7-i] = bus.spi_miso;
      if (i + 1 == nrises && nrises < 8) begin
        tick(HALF);
        if (!abort_by_reset) begin
          bus.spi_sclk = 1'b0;
          bus.spi_cs_n = 1'b1;
          tick(2*HALF);
        end
        return;
      end
      if (i == 7) begin
        exp_rx_q.push_back(d);
        exp_rx_valids++;
        m_rx = d;
        exp_miso_q.push_back(cur_exp_miso);
        obs_miso_q.push_back(obs);
      end
      tick(HALF);
      bus.spi_sclk = 1'b0;
      if (i == 7) begin
        if (last) begin
          bus.spi_cs_n = 1'b1;   // same instant as the final SCLK fall
          tick(2*HALF);
        end else begin
          fb = m_full;
          model_byte_start();
          if (bload_en) begin
            tick(SYNC);
            bus.tx_data = bload_data;
            bus.tx_load = 1'b1;
            if (!fb) begin
              m_hold = bload_data;
              m_full = 1'b1;
            end
            tick(1);
            bus.tx_load = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " miso"},     32'(bus.spi_miso),    32'd0);
    check({tag, " miso_oe"},  32'(bus.spi_miso_oe), 32'd0);
    check({tag, " rx_buf"},   32'(bus.rx_buffer),   32'd0);
    check({tag, " rx_valid"}, 32'(bus.rx_valid),    32'd0);
    check({tag, " tx_ready"}, 32'(bus.tx_ready),    32'd1);
    check({tag, " underrun"}, 32'(bus.tx_underrun), 32'd0);
    check({tag, " busy"},     32'(bus.busy),        32'd0);
  endtask

  task automatic end_of_test(input string tag);
    tick(4);
    check({tag, " underruns"}, 32'(act_underruns), 32'(exp_underruns));
    check({tag, " rx_valids"}, 32'(act_rx_valids), 32'(exp_rx_valids));
    check({tag, " tx_ready"},  32'(bus.tx_ready),  32'(!m_full));
    check({tag, " rx_buffer"}, 32'(bus.rx_buffer), 32'(m_rx));
    check({tag, " miso_oe"},   32'(bus.spi_miso_oe), 32'd0);
    check({tag, " miso_idle"}, 32'(bus.spi_miso),  32'd0);
    check({tag, " busy"},      32'(bus.busy),      32'd0);
  endtask

  // Monitor: counts pulses and retires scoreboard entries.
  always @(negedge clk_in) begin
    if (!reset) begin
      if (bus.tx_underrun) act_underruns++;
      if (bus.rx_valid) begin
        act_rx_valids++;
        if (exp_rx_q.size() == 0) check("rx_unexpected", 32'(bus.rx_valid), 32'd0);
        else check("rx_byte", 32'(bus.rx_buffer), 32'(exp_rx_q.pop_front()));
      end
      if (obs_miso_q.size() != 0 && exp_miso_q.size() != 0)
        check("miso_byte", 32'(obs_miso_q.pop_front()), 32'(exp_miso_q.pop_front()));
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int         nb, nr, rm;
    bit         lastb;

    reset        = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_load  = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(6);
    check_reset_state("reset");

    // 1: preloaded byte out, 3C in
    load(8'hA5);
    tick(2);
    check("t1 tx_ready_loaded", 32'(bus.tx_ready), 32'(!m_full));
    cs_fall();
    tick(4);
    check("t1 busy", 32'(bus.busy), 32'd1);
    check("t1 miso_oe", 32'(bus.spi_miso_oe), 32'd1);
    send_byte(8'h3C, 1, 8, 0, 0, 8'h00, 0, 8'h00);
    end_of_test("t1");

    // 2: no data loaded -> idle byte and one underrun
    cs_fall();
    send_byte(8'h00, 1, 8, 0, 0, 8'h00, 0, 8'h00);
    end_of_test("t2");

    // 3: three bytes under one select, refilled on tx_ready
    load(8'h01);
    tick(2);
    cs_fall();
    send_byte(8'h11, 0, 8, 0, 1, 8'h02, 0, 8'h00);
    send_byte(8'h22, 0, 8, 0, 1, 8'h03, 0, 8'h00);
    send_byte(8'h33, 1, 8, 0, 0, 8'h00, 0, 8'h00);
    end_of_test("t3");

    // 4: abort after 5 rises, then a full frame
    cs_fall();
    send_byte(8'hE7, 0, 5, 0, 0, 8'h00, 0, 8'h00);
    end_of_test("t4_abort");
    cs_fall();
    send_byte(8'h5A, 1, 8, 0, 0, 8'h00, 0, 8'h00);
    end_of_test("t4");

    // 5: second load while full is dropped
    load(8'h77);
    tick(3);
    load(8'h88);
    tick(2);
    check("t5 tx_ready_full", 32'(bus.tx_ready), 32'(!m_full));
    cs_fall();
    send_byte(8'($urandom), 1, 8, 0, 0, 8'h00, 0, 8'h00);
    end_of_test("t5");

    // 6: reset mid-frame with the holding register full
    load(8'h9C);
    tick(2);
    cs_fall();
    send_byte(8'hB4, 0, 4, 1, 1, 8'h4B, 0, 8'h00);
    tick(3);
    reset  = 1'b1;
    m_full = 1'b0;
    m_rx   = 8'h00;
    tick(2);
    check_reset_state("t6 in_reset");
    reset = 1'b0;
    bus.spi_sclk = 1'b0;
    tick(HALF);
    for (int k = 0; k < 4; k++) begin
      bus.spi_mosi = 1'($urandom);
      bus.spi_sclk = 1'b1;
      tick(HALF);
      check("t6 busy_after_reset", 32'(bus.busy), 32'd0);
      bus.spi_sclk = 1'b0;
      tick(HALF);
      check("t6 oe_after_reset", 32'(bus.spi_miso_oe), 32'd0);
    end
    bus.spi_cs_n = 1'b1;
    tick(2*HALF);
    cs_fall();
    send_byte(8'hC3, 1, 8, 0, 0, 8'h00, 0, 8'h00);
    end_of_test("t6");

    // 7: loads coinciding with byte-boundary reloads (empty, then full)
    cs_fall();
    send_byte(8'h81, 0, 8, 0, 0, 8'h00, 1, 8'h6E);
    send_byte(8'h42, 0, 8, 0, 0, 8'h00, 1, 8'h99);
    send_byte(8'h24, 1, 8, 0, 0, 8'h00, 0, 8'h00);
    end_of_test("t7");

    // 8: randomized frames
    for (int f = 0; f < 20; f++) begin
      if ($urandom_range(0, 1) == 1) load(8'($urandom));
      tick(2);
      nb = $urandom_range(1, 3);
      cs_fall();
      for (int b = 0; b < nb; b++) begin
        d     = 8'($urandom);
        lastb = (b == nb - 1);
        nr    = 8;
        if (lastb && $urandom_range(0, 7) == 0) nr = $urandom_range(1, 7);
        rm    = 2 * $urandom_range(0, 1);
        send_byte(d, lastb, nr, 0, rm, 8'($urandom),
                  !lastb && ($urandom_range(0, 3) == 0), 8'($urandom));
      end
      end_of_test("rand");
    end

    tick(20);
    check("exp_rx_left",   32'(exp_rx_q.size()),   32'd0);
    check("exp_miso_left", 32'(exp_miso_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
